// File: rtl/med_pkt_gen_if.sv
// Measurement-FIFO and report-packet bus bundle for med_pkt_gen.
// Latency: n/a (wires only).
// Backpressure: the FIFO side is pop-on-rd_en; the packet side transfers a word when out_wr=1 (out_wr only rises with out_rdy).
// Ports: med_dout/med_empty -> FIFO head and empty flag; med_rd_en <- pop strobe;
//        out_data/out_ctrl/out_wr <- packet words; out_rdy -> downstream can take a word.
// master = the packet generator, slave = the FIFO and output-queue side.
interface med_pkt_gen_if #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8
);
  logic [DATA_WIDTH-1:0] med_dout;
  logic                  med_empty;
  logic                  med_rd_en;
  logic [DATA_WIDTH-1:0] out_data;
  logic [CTRL_WIDTH-1:0] out_ctrl;
  logic                  out_wr;
  logic                  out_rdy;

  modport master (
    input  med_dout, med_empty, out_rdy,
    output med_rd_en, out_data, out_ctrl, out_wr
  );

  modport slave (
    output med_dout, med_empty, out_rdy,
    input  med_rd_en, out_data, out_ctrl, out_wr
  );
endinterface

// File: rtl/med_pkt_gen.sv
// Packs 2-word latency records from the measurement FIFO into NetFPGA-style report packets.
// Latency: a packet starts the cycle after the record that fills it; a partial packet after FLUSH_TIMEOUT idle cycles.
// Backpressure: out_rdy=0 freezes the send FSM with data/ctrl held; no FIFO pops while a packet is being sent.
// Ports: clk, reset (synchronous, active-low), enable (gates new pops only),
//        bus (med_pkt_gen_if.master): med_dout/med_empty/med_rd_en FIFO side, out_data/out_ctrl/out_wr/out_rdy packet side.
// Header word layouts assume a 64-bit data bus.
module med_pkt_gen #(
  parameter int          DATA_WIDTH    = 64,
  parameter int          CTRL_WIDTH    = DATA_WIDTH / 8,
  parameter int          RECS_PER_PKT  = 8,
  parameter int          FLUSH_TIMEOUT = 1024,
  parameter logic [15:0] OUT_PORT      = 16'h0001,
  parameter logic [15:0] SRC_PORT_ID   = 16'h0000,
  parameter logic [47:0] DST_MAC       = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC       = 48'h00_4E_46_32_43_00,
  parameter logic [15:0] ETHERTYPE     = 16'h88B5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  med_pkt_gen_if.master bus
);

  localparam int CNT_W  = 4;                              // RECS_PER_PKT <= 15
  localparam int IDX_W  = CNT_W + 1;                      // {rec_cnt, half}
  localparam int BUF_AW = $clog2(2 * RECS_PER_PKT);
  localparam int TMR_W  = $clog2(FLUSH_TIMEOUT + 1);

  localparam logic [CNT_W-1:0] RECS_MAX = CNT_W'(RECS_PER_PKT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(FLUSH_TIMEOUT - 1);

  typedef enum logic [2:0] {
    COLLECT  = 3'd0,
    HDR_IOQ  = 3'd1,
    HDR_ETH0 = 3'd2,
    HDR_ETH1 = 3'd3,
    PAYLOAD  = 3'd4
  } state_t;

  typedef struct packed {
    logic [15:0] out_port;
    logic [15:0] word_len;
    logic [15:0] src_port;
    logic [15:0] byte_len;
  } ioq_hdr_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      rec_cnt;
  logic [CNT_W-1:0]      pkt_recs;
  logic                  half;
  logic [TMR_W-1:0]      timer;
  logic [15:0]           seq;
  logic [IDX_W-1:0]      word_idx;
  logic [DATA_WIDTH-1:0] rec_buf [2*RECS_PER_PKT];

  logic                  pop;
  logic                  flush_full;
  logic                  flush_tmo;
  logic                  xfer;
  logic                  last_word;
  logic [IDX_W-1:0]      last_idx;
  logic [15:0]           word_len;
  ioq_hdr_t              ioq_hdr;

  logic                  med_rd_en_c;
  logic                  out_wr_c;
  logic [DATA_WIDTH-1:0] out_data_c;
  logic [CTRL_WIDTH-1:0] out_ctrl_c;

  assign flush_full = (rec_cnt == RECS_MAX);
  assign flush_tmo  = (rec_cnt != '0) && !half && (timer == TMR_LAST);

  // Pops are held off on the timeout-flush cycle: a word A taken then would
  // leave half=1 across the packet and misalign the next record.
  assign pop = reset && (state == COLLECT) && enable && !bus.med_empty &&
               (rec_cnt < RECS_MAX) && !flush_tmo;

  assign xfer      = reset && (state != COLLECT) && bus.out_rdy;
  assign last_idx  = {pkt_recs, 1'b0} - IDX_W'(1);
  assign last_word = (state == PAYLOAD) && (word_idx == last_idx);

  assign word_len = 16'd2 + 16'({pkt_recs, 1'b0});
  assign ioq_hdr  = '{out_port: OUT_PORT,
                      word_len: word_len,
                      src_port: SRC_PORT_ID,
                      byte_len: {word_len[12:0], 3'b000}};

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= COLLECT;
    else        state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT:  if (flush_full || flush_tmo) state_nxt = HDR_IOQ;
      HDR_IOQ:  if (xfer) state_nxt = HDR_ETH0;
      HDR_ETH0: if (xfer) state_nxt = HDR_ETH1;
      HDR_ETH1: if (xfer) state_nxt = PAYLOAD;
      PAYLOAD:  if (xfer && last_word) state_nxt = COLLECT;
      default:  state_nxt = COLLECT;
    endcase
  end

  // Outputs
  always_comb begin
    med_rd_en_c = pop;
    out_wr_c    = 1'b0;
    out_data_c  = '0;
    out_ctrl_c  = '0;
    case (state)
      HDR_IOQ: begin
        out_wr_c   = xfer;
        out_ctrl_c = CTRL_WIDTH'(8'hFF);
        out_data_c = DATA_WIDTH'(ioq_hdr);
      end
      HDR_ETH0: begin
        out_wr_c   = xfer;
        out_data_c = DATA_WIDTH'({DST_MAC, SRC_MAC[47:32]});
      end
      HDR_ETH1: begin
        out_wr_c   = xfer;
        out_data_c = DATA_WIDTH'({SRC_MAC[31:0], ETHERTYPE, seq});
      end
      PAYLOAD: begin
        out_wr_c   = xfer;
        out_data_c = rec_buf[BUF_AW'(word_idx)];
        out_ctrl_c = last_word ? CTRL_WIDTH'(8'h01) : '0;
      end
      default: ;
    endcase
  end

  assign bus.med_rd_en = med_rd_en_c;
  assign bus.out_wr    = out_wr_c;
  assign bus.out_data  = out_data_c;
  assign bus.out_ctrl  = out_ctrl_c;

  // Record counters, flush timer, packet sequencing
  always_ff @(posedge clk) begin
    if (!reset) begin
      rec_cnt  <= '0;
      pkt_recs <= '0;
      half     <= 1'b0;
      timer    <= '0;
      seq      <= '0;
      word_idx <= '0;
    end else if (state == COLLECT) begin
      if (pop) begin
        half <= ~half;
        if (half) begin
          rec_cnt <= rec_cnt + CNT_W'(1);
          timer   <= '0;
        end
      end else if ((rec_cnt != '0) && !half) begin
        // Only idle time between complete records counts towards a flush;
        // a half-received record waits for its word B indefinitely.
        timer <= timer + TMR_W'(1);
      end
      if (flush_full || flush_tmo) begin
        pkt_recs <= rec_cnt;
        word_idx <= '0;
      end
    end else if (xfer && (state == PAYLOAD)) begin
      word_idx <= word_idx + IDX_W'(1);
      if (last_word) begin
        seq     <= seq + 16'd1;
        rec_cnt <= '0;
        timer   <= '0;
      end
    end
  end

  // Record buffer, addressed {rec_cnt, half}
  always_ff @(posedge clk) begin
    if (pop) rec_buf[BUF_AW'({rec_cnt, half})] <= bus.med_dout;
  end

endmodule

// File: doc/med_pkt_gen.md
Name: med_pkt_gen

Overview:
- Consumes the measurement FIFO that the Bloom-filter latency stage fills. Each record is two 64-bit words: word A = {src IP, dst IP}, word B = {src port, dst port, latency}.
- Buffers up to RECS_PER_PKT records, then emits one NetFPGA-style report packet on the 64-bit data/ctrl output bus.
- A packet is also emitted after a flush timeout. It sits between the measurement FIFO and the output queues.

Parameters:
- DATA_WIDTH, 64, data bus width.
- CTRL_WIDTH, DATA_WIDTH/8, ctrl bus width.
- RECS_PER_PKT, 8, max records per packet (1..15).
- FLUSH_TIMEOUT, 1024, idle cycles after the last completed record before a partial flush.
- OUT_PORT, 16'h0001, one-hot output port field of the module header.
- SRC_PORT_ID, 16'h0000, source port field of the module header.
- DST_MAC, 48'hFFFFFFFFFFFF, report destination MAC.
- SRC_MAC, 48'h00_4E_46_32_43_00, report source MAC.
- ETHERTYPE, 16'h88B5, report EtherType.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-low: reset==0 at a clk edge resets the block.
- enable  in  1  when 0, no new FIFO pops; a packet already in progress completes.
- med_dout  in  DATA_WIDTH  fall-through FIFO head word, valid while !med_empty.
- med_empty  in  1  measurement FIFO empty.
- med_rd_en  out  1  pops the FIFO head this cycle.
- out_data  out  DATA_WIDTH  output packet word.
- out_ctrl  out  CTRL_WIDTH  output ctrl (0xFF module header, 0x00 body, 0x01 last word).
- out_wr  out  1  word transferred this cycle.
- out_rdy  in  1  downstream can accept a word this cycle.

Behaviour:
- Reset (reset==0 at an edge): state=COLLECT; rec_cnt=0; half=0; timer=0; seq=0. med_rd_en=0, out_wr=0, out_data=0, out_ctrl=0.
  - Reset mid-packet aborts the packet; out_wr is 0 from the next cycle.
- Buffer: 2*RECS_PER_PKT x 64 registers or RAM, indexed {rec_cnt, half}.
- COLLECT:
  - med_rd_en = enable && !med_empty && rec_cnt<RECS_PER_PKT (combinational). med_dout is written to buf[2*rec_cnt+half] in the same cycle.
  - half toggles on each pop. On the pop that completes a record (half==1): rec_cnt++, timer=0.
  - timer increments each cycle while rec_cnt>0 && half==0 && no pop occurs. While half==1, the timer holds: the block waits indefinitely for word B.
  - Go to HDR_IOQ when either:
    - rec_cnt==RECS_PER_PKT, including the cycle right after the completing pop; or
    - rec_cnt>0 && half==0 && timer==FLUSH_TIMEOUT-1.
  - The count is latched as pkt_recs.
  - No pop occurs in any state other than COLLECT. Upstream backs up.
- Send states, in order HDR_IOQ -> HDR_ETH0 -> HDR_ETH1 -> PAYLOAD (2*pkt_recs words) -> COLLECT.
  - out_wr = out_rdy while in a send state. The state and word index advance only when out_wr=1. With out_rdy=0, out_data/out_ctrl hold and nothing is duplicated or dropped.
  - HDR_IOQ: ctrl 0xFF; data {OUT_PORT, word_len, SRC_PORT_ID, byte_len}.
    - word_len = 2+2*pkt_recs.
    - byte_len = 8*word_len.
    - Both fields are 16 bits, zero-extended.
  - HDR_ETH0: ctrl 0x00; data {DST_MAC, SRC_MAC[47:32]}.
  - HDR_ETH1: ctrl 0x00; data {SRC_MAC[31:0], ETHERTYPE, seq}.
  - PAYLOAD: buf[0..2*pkt_recs-1] in order. ctrl is 0x00, except the final word, which is 0x01.
  - After the last word transfers: seq = seq+1 (16-bit, FFFF wraps to 0000), rec_cnt=0, timer=0, and the state returns to COLLECT.
- Minimum packet: 5 words (1 record). Maximum: 3+2*RECS_PER_PKT words.
- enable=0 in COLLECT: pops stop, the timer still runs, and a timeout flush of complete records still occurs.

Test Plan:
1. Default params, 8 records (16 words) preloaded, out_rdy=1 -> 19 words emitted.
   - word0 = 0x0001_0012_0000_0090, ctrl 0xFF.
   - word2 low 16 bits = 0x0000 (seq 0).
   - words 3..18 equal the input in order; word 18 has ctrl 0x01.
   - med_rd_en is high for exactly 16 cycles.
2. 3 records, then empty -> no out_wr for 1023 cycles after the 3rd record completes, then a packet with header 0x0001_0008_0000_0040, 9 words total, last ctrl 0x01.
3. Same as test 1 with out_rdy toggling 1,0,0,1,... -> identical 19-word sequence, out_wr never high while out_rdy=0. A following packet carries seq 0x0001.
4. 1 word (word A only), then empty for 5000 cycles -> no output. Then push word B -> packet with 1 record 1024 cycles later; word_len 0x0004.
5. reset=0 for one cycle during PAYLOAD word 5 -> out_wr=0 from the next cycle. The next packet after 8 more records has seq 0x0000 and contains only the new records.
6. enable=0 with 10 records queued -> no pops. Raise enable -> 8-record packet, then a 2-record packet after the timeout.
